// File: rtl/pfd_charge_pump.sv
// Digital phase-frequency detector with a saturating charge-pump integrator,
// NCO tone output and a pulse-width based lock detector.
module pfd_charge_pump #(
    parameter logic [7:0] CTRL_INIT = 8'd128,
    parameter logic [7:0] STEP      = 8'd1,
    parameter int         LOCK_TOL  = 2,
    parameter int         LOCK_CNT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ref_in,
    input  logic       fb_in,
    output logic       up,
    output logic       dn,
    output logic [7:0] ctrl,
    output logic       cp_out,
    output logic       v_in,
    output logic       locked
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DN
    } state_t;

    state_t        state;
    logic          ref_s1, ref_s2, ref_s3;
    logic          fb_s1, fb_s2, fb_s3;
    logic          ref_rise, fb_rise;
    logic [3:0]    wcnt;
    logic [LW-1:0] lcnt;
    logic [LW-1:0] lcnt_next;
    logic [LW-1:0] lcnt_inc;
    logic          width_ok;
    logic [8:0]    ctrl_sum;
    logic [7:0]    acc;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the same pre-edge values; blocking here would collapse the
    // synchroniser chain into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_s3 <= 1'b0;
            fb_s1  <= 1'b0;
            fb_s2  <= 1'b0;
            fb_s3  <= 1'b0;
        end else begin
            ref_s1 <= ref_in;
            ref_s2 <= ref_s1;
            ref_s3 <= ref_s2;
            fb_s1  <= fb_in;
            fb_s2  <= fb_s1;
            fb_s3  <= fb_s2;
        end
    end

    assign ref_rise = ref_s2 & ~ref_s3;
    assign fb_rise  = fb_s2 & ~fb_s3;

    assign lcnt_inc = (lcnt == LOCK_MAX) ? lcnt : lcnt + LW'(1);
    assign width_ok = (int'(wcnt) <= LOCK_TOL);

    // NOTE: the default assignment first keeps this block free of inferred
    // latches on paths that do not update the lock count.
    always_comb begin
        lcnt_next = lcnt;
        case (state)
            ST_IDLE: if (ref_rise && fb_rise) lcnt_next = lcnt_inc;
            ST_UP:   if (fb_rise)  lcnt_next = width_ok ? lcnt_inc : '0;
            ST_DN:   if (ref_rise) lcnt_next = width_ok ? lcnt_inc : '0;
            default: lcnt_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            up     <= 1'b0;
            dn     <= 1'b0;
            wcnt   <= 4'd0;
            lcnt   <= '0;
            locked <= 1'b0;
        end else begin
            lcnt   <= lcnt_next;
            locked <= (lcnt_next == LOCK_MAX);
            case (state)
                ST_IDLE: begin
                    if (ref_rise && !fb_rise) begin
                        state <= ST_UP;
                        up    <= 1'b1;
                        wcnt  <= 4'd0;
                    end else if (fb_rise && !ref_rise) begin
                        state <= ST_DN;
                        dn    <= 1'b1;
                        wcnt  <= 4'd0;
                    end
                end
                ST_UP: begin
                    wcnt <= (wcnt == 4'd15) ? wcnt : wcnt + 4'd1;
                    if (fb_rise) begin
                        state <= ST_IDLE;
                        up    <= 1'b0;
                    end
                end
                ST_DN: begin
                    wcnt <= (wcnt == 4'd15) ? wcnt : wcnt + 4'd1;
                    if (ref_rise) begin
                        state <= ST_IDLE;
                        dn    <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    up    <= 1'b0;
                    dn    <= 1'b0;
                end
            endcase
        end
    end

    // Integrator acts on the registered pulses, so it trails up/dn by one edge.
    assign ctrl_sum = {1'b0, ctrl} + {1'b0, STEP};

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= CTRL_INIT;
        end else if (up) begin
            ctrl <= ctrl_sum[8] ? 8'hFF : ctrl_sum[7:0];
        end else if (dn) begin
            ctrl <= (ctrl < STEP) ? 8'd0 : ctrl - STEP;
        end
    end

    // A zero control word parks the NCO so the tone freezes rather than drifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= 8'd0;
            cp_out <= 1'b0;
            v_in   <= (CTRL_INIT != 8'd0);
        end else begin
            v_in <= (ctrl != 8'd0);
            if (ctrl != 8'd0) begin
                acc    <= acc + ctrl;
                cp_out <= acc[7];
            end
        end
    end

endmodule

// File: tb/tb_pfd_charge_pump.sv
// Directed bench for pfd_charge_pump: pulse widths, integration, saturation,
// lock detection, NCO tone and mid-pulse reset.
module tb_pfd_charge_pump;

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_in;
    logic       fb_in;
    logic       up;
    logic       dn;
    logic [7:0] ctrl;
    logic       cp_out;
    logic       v_in;
    logic       locked;

    int errors = 0;
    int checks = 0;

    pfd_charge_pump dut (
        .clk    (clk),
        .rst    (rst),
        .ref_in (ref_in),
        .fb_in  (fb_in),
        .up     (up),
        .dn     (dn),
        .ctrl   (ctrl),
        .cp_out (cp_out),
        .v_in   (v_in),
        .locked (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    // Leader rises now, follower n clocks later (n = 0: both together).
    task automatic pulse(input bit ref_lead, input int n,
                         output int up_cycles, output int dn_cycles, output int first);
        up_cycles = 0;
        dn_cycles = 0;
        first     = -1;
        if (n == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
        end else if (ref_lead) begin
            ref_in = 1'b1;
        end else begin
            fb_in = 1'b1;
        end
        for (int i = 1; i <= n + 8; i++) begin
            tick(1);
            if (up) up_cycles++;
            if (dn) dn_cycles++;
            if ((up || dn) && first < 0) first = i;
            if (i == n) begin
                ref_in = 1'b1;
                fb_in  = 1'b1;
            end
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(4);
    endtask

    int  upc, dnc, first, toggles, bad_gaps, last_toggle;
    logic prev_cp;

    initial begin
        do_reset();
        rst = 1'b1;
        tick(1);
        check("rst_up", up, 0);
        check("rst_dn", dn, 0);
        check("rst_ctrl", ctrl, 128);
        check("rst_locked", locked, 0);
        check("rst_v_in", v_in, 1);
        check("rst_cp_out", cp_out, 0);
        rst = 1'b0;

        // Reference leads by 5 clocks.
        pulse(1'b1, 5, upc, dnc, first);
        check("lead5_up_cycles", upc, 5);
        check("lead5_dn_cycles", dnc, 0);
        check("lead5_latency", first, 3);
        check("lead5_ctrl", ctrl, 133);

        // Feedback leads by 3 clocks.
        do_reset();
        pulse(1'b0, 3, upc, dnc, first);
        check("lag3_dn_cycles", dnc, 3);
        check("lag3_up_cycles", upc, 0);
        check("lag3_latency", first, 3);
        check("lag3_ctrl", ctrl, 125);

        // In-phase edges build lock; a wide pulse breaks it.
        do_reset();
        upc = 0;
        dnc = 0;
        for (int e = 1; e <= 15; e++) begin
            int u, d, f;
            pulse(1'b1, 0, u, d, f);
            upc += u;
            dnc += d;
        end
        check("lock_after15", locked, 0);
        pulse(1'b1, 0, upc, dnc, first);
        check("lock_after16", locked, 1);
        pulse(1'b1, 0, upc, dnc, first);
        check("lock_after17", locked, 1);
        check("lock_ctrl_hold", ctrl, 128);
        check("lock_no_pulses", upc + dnc, 0);
        pulse(1'b1, 5, upc, dnc, first);
        check("lock_lost", locked, 0);

        // Upper saturation.
        do_reset();
        pulse(1'b1, 126, upc, dnc, first);
        check("sat_hi_pre", ctrl, 254);
        pulse(1'b1, 4, upc, dnc, first);
        check("sat_hi_up_cycles", upc, 4);
        check("sat_hi_ctrl", ctrl, 255);

        // Lower saturation and NCO freeze.
        pulse(1'b0, 254, upc, dnc, first);
        check("sat_lo_pre", ctrl, 1);
        check("sat_lo_pre_v_in", v_in, 1);
        pulse(1'b0, 3, upc, dnc, first);
        check("sat_lo_dn_cycles", dnc, 3);
        check("sat_lo_ctrl", ctrl, 0);
        check("sat_lo_v_in", v_in, 0);
        toggles = 0;
        prev_cp = cp_out;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cp_out !== prev_cp) toggles++;
            prev_cp = cp_out;
        end
        check("cp_frozen_toggles", toggles, 0);

        // ctrl = 64 gives a period-4 tone.
        do_reset();
        pulse(1'b0, 64, upc, dnc, first);
        check("nco_ctrl", ctrl, 64);
        toggles     = 0;
        bad_gaps    = 0;
        last_toggle = -1;
        prev_cp     = cp_out;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (cp_out !== prev_cp) begin
                if (last_toggle >= 0 && (i - last_toggle) != 2) bad_gaps++;
                last_toggle = i;
                toggles++;
            end
            prev_cp = cp_out;
        end
        check("nco_toggles", toggles, 8);
        check("nco_bad_gaps", bad_gaps, 0);

        // Reset in the third cycle of an up pulse.
        do_reset();
        ref_in = 1'b1;
        tick(5);
        check("mid_up_pre", up, 1);
        check("mid_ctrl_pre", ctrl, 130);
        rst    = 1'b1;
        ref_in = 1'b0;
        tick(1);
        check("mid_up_after_rst", up, 0);
        check("mid_ctrl_after_rst", ctrl, 128);
        check("mid_locked_after_rst", locked, 0);
        rst = 1'b0;
        upc = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (up || dn) upc++;
        end
        check("mid_no_stale_pulse", upc, 0);
        check("mid_ctrl_settled", ctrl, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pfd_charge_pump.md
PFD_CHARGE_PUMP -- requirements
Module: pfd_charge_pump

Interface
REQ-001 Parameter CTRL_INIT, default 8'd128: ctrl value loaded at reset.
REQ-002 Parameter STEP, default 8'd1: ctrl change per clock while up or dn is high.
REQ-003 Parameter LOCK_TOL, default 2: maximum up/dn pulse width, in clocks, that counts as in-phase.
REQ-004 Parameter LOCK_CNT, default 16: consecutive in-phase comparisons required to assert locked.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 ref_in  input  1  reference clock, asynchronous to clk.
REQ-009 fb_in  input  1  divided feedback from the VCO, asynchronous to clk.
REQ-010 up  output  1  PFD up pulse: reference leads.
REQ-011 dn  output  1  PFD down pulse: feedback leads.
REQ-012 ctrl  output  8  charge-pump control word (integrated loop voltage).
REQ-013 cp_out  output  1  numerically controlled tone whose frequency is proportional to ctrl; feeds the VCO cp_out input.
REQ-014 v_in  output  1  control-valid flag, high when ctrl is nonzero; feeds the VCO v_in input.
REQ-015 locked  output  1  loop-lock indication.

Function
REQ-016 Synchroniser: ref_in and fb_in SHALL each pass through two flops (s1, s2), plus a third flop s3 for edge detection.
REQ-017 Edge detect: ref_rise = ref_s2 & ~ref_s3 and fb_rise = fb_s2 & ~fb_s3; each is a single-cycle pulse per input rising edge.
REQ-018 PFD FSM states: IDLE (up=0, dn=0), UP (up=1, dn=0), DN (up=0, dn=1); up and dn are decoded from registered state and are never high together.
REQ-019 IDLE transitions: ref_rise only -> UP; fb_rise only -> DN; both in the same cycle -> stay in IDLE and count as an in-phase event of width 0.
REQ-020 UP transitions: fb_rise -> IDLE, including when ref_rise arrives in the same cycle; ref_rise alone -> stay in UP.
REQ-021 DN transitions: ref_rise -> IDLE, including when fb_rise arrives in the same cycle; fb_rise alone -> stay in DN.
REQ-022 Latency: when ref_in goes high before clk edge k, up SHALL be high after edge k+2 (three-edge latency); fb_in to dn has the same latency.
REQ-023 Charge pump: on each edge, up=1 -> ctrl += STEP, saturating at 8'd255; dn=1 -> ctrl -= STEP, saturating at 8'd0; otherwise ctrl holds.
REQ-024 Because the charge pump reads registered up/dn, ctrl SHALL first change one edge after up or dn rises.
REQ-025 Width counter: a 4-bit wcnt SHALL clear on entry to UP or DN and increment each cycle spent in UP or DN, saturating at 15.
REQ-026 Lock counter, on each exit from UP/DN to IDLE: if wcnt <= LOCK_TOL, lcnt increments, saturating at LOCK_CNT; otherwise lcnt clears to 0.
REQ-027 Each simultaneous-edge event in IDLE SHALL increment lcnt, saturating at LOCK_CNT.
REQ-028 locked SHALL be registered and high exactly while lcnt == LOCK_CNT.
REQ-029 NCO: an 8-bit phase accumulator acc SHALL update acc <= acc + ctrl every clock, modulo 256; cp_out = registered acc[7].
REQ-030 If ctrl == 0, acc holds and cp_out is frozen at its current value.
REQ-031 v_in SHALL be a registered (ctrl != 0), one clock behind ctrl.

Reset
REQ-032 While rst=1 at a clock edge: all synchroniser flops = 0, state = IDLE, up = dn = 0, ctrl = CTRL_INIT, acc = 0, cp_out = 0, wcnt = 0, lcnt = 0, locked = 0, v_in = 1 (CTRL_INIT nonzero; v_in = 0 if CTRL_INIT = 0).
REQ-033 A reset asserted mid-pulse SHALL abort the pulse: up/dn are low after that edge, and ctrl returns to CTRL_INIT with no partial update.
REQ-034 Edges already held in the synchroniser at reset SHALL be discarded; the first edge detected after reset is the first 0->1 transition seen by s2.

Verification
REQ-035 ref_in rises 5 clocks before fb_in, ctrl=128 -> up high for 5 cycles, then ctrl=133 and dn never high.
REQ-036 fb_in rises 3 clocks before ref_in, ctrl=128 -> dn high for 3 cycles, then ctrl=125.
REQ-037 ref_in and fb_in driven identically for 16 rising edges -> locked=1 after the 16th event; then a 5-cycle lead -> locked=0.
REQ-038 ctrl=254 with ref_in leading by 4 cycles -> ctrl saturates at 255; separately, ctrl=1 with a 3-cycle dn pulse -> ctrl=0, v_in=0, cp_out frozen.
REQ-039 ctrl=64 held with no edges -> cp_out toggles every 2 clocks (period 4).
REQ-040 rst=1 in the 3rd cycle of an up pulse -> up=0 and ctrl=128 on the next edge; locked=0.
